// File: rtl/and_operand_sweeper.sv
// and_operand_sweeper: registered operand generator for the AND-gate datapath.
// On start it walks a 2*INPUT_WIDTH-bit pattern index through every value,
// splitting it into operand A (low half) and operand B (high half), holding
// each pair for HOLD_CYCLES clocks. Flags valid, last-pattern and completion.
//
// Optional feature: define AND_OPGEN_REPEAT_EN to add the repeat_in port, which
// lets the sweep wrap back to pattern 0 instead of finishing through DONE.
//
// Every output is decoded from registered state only, so no input reaches an
// output combinationally and the async reset clears all outputs at once.

module and_operand_sweeper #(
  parameter int unsigned INPUT_WIDTH = 1,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic                   clock_in,
  input  logic                   reset_n_in,
  input  logic                   start_in,
`ifdef AND_OPGEN_REPEAT_EN
  input  logic                   repeat_in,
`endif
  output logic [INPUT_WIDTH-1:0] a_out,
  output logic [INPUT_WIDTH-1:0] b_out,
  output logic                   valid_out,
  output logic                   last_out,
  output logic                   busy_out,
  output logic                   done_out
);

  localparam int unsigned IdxW  = 2 * INPUT_WIDTH;
  // A single-cycle hold still needs a 1-bit counter so the logic stays uniform.
  localparam int unsigned HcntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HcntW-1:0] HcntMax = HcntW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [HcntW-1:0] hcnt_q, hcnt_d;

  logic hold_end;
  logic idx_last;

  assign hold_end = (hcnt_q == HcntMax);
  assign idx_last = &idx_q;

  // State, pattern index and hold counter; reset aborts any sweep immediately.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= StIdle;
      idx_q   <= '0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hcnt_q  <= hcnt_d;
    end
  end

  // Next-state: start only in IDLE, step hold/index in SWEEP, DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hcnt_d  = hcnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          state_d = StSweep;
          idx_d   = '0;
          hcnt_d  = '0;
        end
      end
      StSweep: begin
        if (!hold_end) begin
          hcnt_d = hcnt_q + 1'b1;
        end else begin
          hcnt_d = '0;
          // Termination is decided on the all-ones index before the wrap happens.
          if (idx_last) begin
            idx_d = '0;
`ifdef AND_OPGEN_REPEAT_EN
            if (!repeat_in) begin
              state_d = StDone;
            end
`else
            state_d = StDone;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        idx_d   = '0;
        hcnt_d  = '0;
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
        hcnt_d  = '0;
      end
    endcase
  end

  // Outputs decoded from registered state; operands are forced to 0 outside SWEEP.
  always_comb begin
    a_out     = '0;
    b_out     = '0;
    valid_out = 1'b0;
    last_out  = 1'b0;
    busy_out  = 1'b0;
    done_out  = 1'b0;
    if (state_q == StSweep) begin
      a_out     = idx_q[INPUT_WIDTH-1:0];
      b_out     = idx_q[IdxW-1:INPUT_WIDTH];
      valid_out = 1'b1;
      busy_out  = 1'b1;
      last_out  = idx_last;
    end
    if (state_q == StDone) begin
      done_out = 1'b1;
    end
  end

endmodule

// File: tb/tb_and_operand_sweeper.sv
// Directed bench for and_operand_sweeper: a 1-bit/hold-1 instance and a
// 2-bit/hold-3 instance share clock and reset; each has its own start.
module tb_and_operand_sweeper;

  logic       clk;
  logic       rst_n;
  logic       start1;
  logic       start2;
  logic       rep1;
  logic       rep2;
  logic [0:0] a1, b1;
  logic       v1, l1, bz1, d1;
  logic [1:0] a2, b2;
  logic       v2, l2, bz2, d2;
  logic       and_q;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  and_operand_sweeper #(
    .INPUT_WIDTH(1),
    .HOLD_CYCLES(1)
  ) u_dut1 (
    .clock_in  (clk),
    .reset_n_in(rst_n),
    .start_in  (start1),
`ifdef AND_OPGEN_REPEAT_EN
    .repeat_in (rep1),
`endif
    .a_out     (a1),
    .b_out     (b1),
    .valid_out (v1),
    .last_out  (l1),
    .busy_out  (bz1),
    .done_out  (d1)
  );

  and_operand_sweeper #(
    .INPUT_WIDTH(2),
    .HOLD_CYCLES(3)
  ) u_dut2 (
    .clock_in  (clk),
    .reset_n_in(rst_n),
    .start_in  (start2),
`ifdef AND_OPGEN_REPEAT_EN
    .repeat_in (rep2),
`endif
    .a_out     (a2),
    .b_out     (b2),
    .valid_out (v2),
    .last_out  (l2),
    .busy_out  (bz2),
    .done_out  (d2)
  );

  // Stand-in for the downstream registered AND stage.
  always_ff @(posedge clk) and_q <= a1[0] & b1[0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                      input logic ev, input logic el, input logic ed);
    chk({tag, ".a"}, 8'(a1), ea);
    chk({tag, ".b"}, 8'(b1), eb);
    chk({tag, ".valid"}, 8'(v1), 8'(ev));
    chk({tag, ".busy"}, 8'(bz1), 8'(ev));
    chk({tag, ".last"}, 8'(l1), 8'(el));
    chk({tag, ".done"}, 8'(d1), 8'(ed));
  endtask

  task automatic chk2(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                      input logic ev, input logic el, input logic ed);
    chk({tag, ".a"}, 8'(a2), ea);
    chk({tag, ".b"}, 8'(b2), eb);
    chk({tag, ".valid"}, 8'(v2), 8'(ev));
    chk({tag, ".busy"}, 8'(bz2), 8'(ev));
    chk({tag, ".last"}, 8'(l2), 8'(el));
    chk({tag, ".done"}, 8'(d2), 8'(ed));
  endtask

  initial begin
    logic [1:0] p2;
    logic [3:0] p4;
    int last_seen;
    int valid_seen;
    int done_seen;

    rst_n  = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    rep1   = 1'b0;
    rep2   = 1'b0;
    #2;
    chk1("in_reset", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    chk2("in_reset2", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b1;

    // Idle with start low for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      step();
      chk1("idle", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      chk2("idle2", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    end

    // Basic sweep, width 1 / hold 1: (0,0),(1,0),(0,1),(1,1).
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      p2 = 2'(i);
      chk1("sweep1", 8'(p2[0]), 8'(p2[1]), 1'b1, (i == 3), 1'b0);
      if (i == 3) chk("and_stage", 8'(and_q), 8'd0);
      step();
    end
    chk1("done1", 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    chk("and_stage_last", 8'(and_q), 8'd1);
    step();
    chk1("after_done1", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Width 2 / hold 3: 16 patterns x 3 cycles = 48 valid cycles.
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    valid_seen = 0;
    last_seen  = 0;
    for (int p = 0; p < 16; p++) begin
      for (int h = 0; h < 3; h++) begin
        p4 = 4'(p);
        chk2("sweep2", 8'(p4[1:0]), 8'(p4[3:2]), 1'b1, (p == 15), 1'b0);
        if (v2) valid_seen++;
        if (l2) last_seen++;
        step();
      end
    end
    chk2("done2", 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    chk("valid_count2", 8'(valid_seen), 8'd48);
    chk("last_count2", 8'(last_seen), 8'd3);
    step();
    chk2("after_done2", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Start held high throughout: same sweep, one done, restart 2 cycles after last valid.
    start1 = 1'b1;
    step();
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      p2 = 2'(i);
      chk1("hold_start", 8'(p2[0]), 8'(p2[1]), 1'b1, (i == 3), 1'b0);
      step();
    end
    chk1("hold_start_done", 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    if (d1) done_seen++;
    step();
    chk1("hold_start_idle", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    step();
    chk1("hold_start_restart", 8'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    start1 = 1'b0;
    for (int i = 1; i < 4; i++) begin
      step();
      if (d1) done_seen++;
    end
    step();
    chk1("restart_done", 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    if (d1) done_seen++;
    chk("done_pulses", 8'(done_seen), 8'd2);
    step();

    // Mid-sweep reset while (0,1) is held.
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    step();
    chk1("pre_reset", 8'd0, 8'd1, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("async_reset", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    done_seen  = 0;
    valid_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (d1) done_seen++;
      if (v1) valid_seen++;
    end
    chk("no_done_after_abort", 8'(done_seen), 8'd0);
    chk("no_valid_after_abort", 8'(valid_seen), 8'd0);

`ifdef AND_OPGEN_REPEAT_EN
    // Three passes: repeat high at the end of passes 1 and 2, low at pass 3.
    rep1   = 1'b1;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    valid_seen = 0;
    last_seen  = 0;
    done_seen  = 0;
    for (int i = 0; i < 12; i++) begin
      p2 = 2'(i % 4);
      if (i == 8) rep1 = 1'b0;
      chk1("repeat", 8'(p2[0]), 8'(p2[1]), 1'b1, ((i % 4) == 3), 1'b0);
      if (v1) valid_seen++;
      if (l1) last_seen++;
      if (d1) done_seen++;
      step();
    end
    chk1("repeat_done", 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    chk("repeat_valid", 8'(valid_seen), 8'd12);
    chk("repeat_last", 8'(last_seen), 8'd3);
    chk("repeat_no_early_done", 8'(done_seen), 8'd0);
    step();
    chk1("repeat_idle", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
